if_fetch: RTL and testbench
===========================

// Module: if_fetch
// PURPOSE
//  Instruction-fetch stage directly downstream of the PC register. Takes the current pc/ce,
//  reads the 32-bit instruction as four byte reads over the shared 8-bit memory port,
//  assembles it little-endian and presents {pc, inst, valid} to the IF/ID register.
//  Requests a pipeline stall while fetching; aborts on a branch redirect (set_pc_i).
// PARAMETERS
//  ADDR_W   32  instruction address width (matches `InstAddrBus)
//  INST_W   32  instruction width (matches `InstBus); fixed 4 bytes
// PORTS
//  clk          in   1       system clock, all state on posedge
//  rst          in   1       synchronous reset, active-low (rst==0 resets)
//  pc_i         in   ADDR_W  current pc from PC register
//  ce_i         in   1       PC register chip enable; 0 => no fetch
//  set_pc_i     in   1       branch/jump redirect (same strobe the PC register sees)
//  stall        in   6       pipeline stall vector; stall[1]=1 => IF/ID holds
//  mem_req_o    out  1       byte read request
//  mem_addr_o   out  ADDR_W  byte address = fpc + issue_cnt
//  mem_gnt_i    in   1       arbiter grant; request issued in a cycle with req&gnt
//  mem_din_i    in   8       read byte, valid the cycle after a granted issue
//  stallreq_o   out  1       stall request to pipeline control
//  if_pc_o      out  ADDR_W  pc of presented instruction
//  if_inst_o    out  INST_W  assembled instruction
//  if_valid_o   out  1       if_inst_o/if_pc_o valid; 0 = bubble
// BEHAVIOUR
//  Reset (rst==0): state=IDLE, issue_cnt=0, cap_cnt=0, pend=0, fpc=0; if_pc_o=0,
//   if_inst_o=0, if_valid_o=0, mem_req_o=0, mem_addr_o=0, stallreq_o=0. Reset mid-fetch abandons all bytes.
//  FSM: IDLE -> FETCH -> DONE -> IDLE.
//  IDLE: if ce_i & !set_pc_i: latch fpc<=pc_i, counters<=0, go FETCH. stallreq_o=ce_i.
//  FETCH: mem_req_o=(issue_cnt<4); on req&gnt issue byte issue_cnt, issue_cnt++, pend<=1,
//   pend_idx<=issue_cnt; else pend<=0. When pend: byte[pend_idx]<=mem_din_i, cap_cnt++.
//   Gnt low only delays issues; an already-issued byte is always captured next cycle.
//   When byte 3 captured: if_inst_o<={b3,b2,b1,b0}, if_pc_o<=fpc, if_valid_o<=1, go DONE.
//   stallreq_o=1 throughout.
//  DONE: stallreq_o=0, outputs held. If stall[1]==0 (IF/ID accepts this cycle): next
//   if_valid_o=0, go IDLE (PC register advances pc in the same cycle). Else hold.
//  Latency, gnt always 1: IDLE sample cycle T, issues T+1..T+4, if_valid_o=1 in T+6.
//  set_pc_i=1 in any state: next state IDLE, if_valid_o<=0, counters<=0, pend<=0;
//   in-flight byte discarded; mem_req_o=0 from next cycle. Priority: rst > set_pc_i > FSM.
//  ce_i=0 in FETCH: treated like set_pc_i (abort to IDLE).
//  mem_addr_o = fpc + issue_cnt (ADDR_W wrap, no carry checks); 0 when mem_req_o=0.
//  Misaligned pc fetched as-is (no exception).
// STRUCTURE
//  defines.v (shared): `InstAddrBus, `InstBus, `Stop/`NoStop, `ZeroWord, and a new
//   `RstActiveLow (1'b0); FSM state encodings stay local (localparam).
//  One sub-module: fetch_byte_asm (4x8 byte regs, indexed write, clear, 32-bit concat out).
// TESTING
//  1 Reset: rst=0 for 3 cycles mid-FETCH -> all outputs 0, mem_req_o=0, state IDLE.
//  2 Basic: pc_i=0x1000, gnt=1, mem bytes 0x13,0x05,0x10,0x00 at 0x1000..3 ->
//    addrs 0x1000..0x1003 on T+1..T+4, if_inst_o=0x00100513, if_pc_o=0x1000, valid at T+6.
//  3 Grant gaps: gnt low on T+2 and T+3 -> addr 0x1001 held, same inst, valid at T+8.
//  4 Redirect: set_pc_i after byte 1 issued, pc_i->0x2000 -> old byte dropped,
//    valid stays 0, next fetch at 0x2000 starting addr 0x2000.
//  5 Back-pressure: stall[1]=1 for 4 cycles in DONE -> outputs stable, stallreq_o=0,
//    no mem_req_o; release -> valid drops, next fetch samples pc+4.
//  6 Wrap: pc_i=0xFFFFFFFE -> addrs 0xFFFFFFFE,0xFFFFFFFF,0x0,0x1.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// Shared constants and types for the instruction-fetch stage.
// Bus widths track the core-wide instruction address and data buses.
package if_fetch_pkg;

    localparam int   INST_ADDR_W = 32;
    localparam int   INST_W_DEF  = 32;
    localparam int   INST_BYTES  = 4;
    localparam logic RST_ACTIVE  = 1'b0;
    localparam logic STOP        = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DONE  = 2'd2
    } fetch_state_e;

    function automatic logic [31:0] le_word(
        input logic [7:0] b3,
        input logic [7:0] b2,
        input logic [7:0] b1,
        input logic [7:0] b0
    );
        return {b3, b2, b1, b0};
    endfunction

endpackage

// File: rtl/if_fetch_byte_asm.sv
// Four byte lanes of the instruction being fetched.
// o_word already includes a byte written this cycle.
module fetch_byte_asm
    import if_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clr,
    input  logic        i_we,
    input  logic [1:0]  i_idx,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word
);

    logic [7:0] r_byte [INST_BYTES];
    logic [7:0] w_nxt  [INST_BYTES];

    always_ff @(posedge clk) begin
        if (rst == RST_ACTIVE || i_clr) begin
            for (int i = 0; i < INST_BYTES; i++) begin
                r_byte[i] <= '0;
            end
        end else if (i_we) begin
            r_byte[i_idx] <= i_byte;
        end
    end

    always_comb begin
        w_nxt = r_byte;
        if (i_we) begin
            w_nxt[i_idx] = i_byte;
        end
    end

    assign o_word = le_word(w_nxt[3], w_nxt[2], w_nxt[1], w_nxt[0]);

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: four byte reads over the shared 8-bit port,
// assembled little-endian and handed to the IF/ID register.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter int ADDR_W = INST_ADDR_W,
    parameter int INST_W = INST_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              ce_i,
    input  logic              set_pc_i,
    input  logic [5:0]        stall,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_gnt_i,
    input  logic [7:0]        mem_din_i,
    output logic              stallreq_o,
    output logic [ADDR_W-1:0] if_pc_o,
    output logic [INST_W-1:0] if_inst_o,
    output logic              if_valid_o
);

    fetch_state_e      r_state;
    fetch_state_e      w_next;
    logic [2:0]        r_issue_cnt;
    logic [2:0]        r_cap_cnt;
    logic              r_pend;
    logic [1:0]        r_pend_idx;
    logic [ADDR_W-1:0] r_fpc;
    logic [ADDR_W-1:0] r_pc;
    logic [INST_W-1:0] r_inst;
    logic              r_valid;

    logic              w_rst;
    logic              w_req;
    logic              w_stallreq;
    logic              w_start;
    logic              w_flush;
    logic              w_last;
    logic              w_release;
    logic              w_issue;
    logic              w_we;
    logic              w_clr;
    logic [31:0]       w_word;
    logic              w_unused_stall;

    assign w_rst          = (rst == RST_ACTIVE);
    assign w_unused_stall = ^{stall[5:2], stall[0]};

    always_ff @(posedge clk) begin
        if (w_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_req      = 1'b0;
        w_stallreq = 1'b0;
        w_start    = 1'b0;
        w_flush    = 1'b0;
        w_last     = 1'b0;
        w_release  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_stallreq = ce_i;
                if (set_pc_i) begin
                    w_flush = 1'b1;
                end else if (ce_i) begin
                    w_start = 1'b1;
                    w_next  = ST_FETCH;
                end
            end
            ST_FETCH: begin
                w_stallreq = 1'b1;
                w_req      = (r_issue_cnt < 3'(INST_BYTES));
                // losing ce mid-fetch is handled exactly like a redirect
                if (set_pc_i || !ce_i) begin
                    w_flush = 1'b1;
                    w_next  = ST_IDLE;
                end else if (r_pend && r_cap_cnt == 3'(INST_BYTES - 1)) begin
                    w_last = 1'b1;
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (set_pc_i) begin
                    w_flush = 1'b1;
                    w_next  = ST_IDLE;
                end else if (stall[1] != STOP) begin
                    w_release = 1'b1;
                    w_next    = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
        if (w_rst) begin
            w_next     = ST_IDLE;
            w_req      = 1'b0;
            w_stallreq = 1'b0;
            w_start    = 1'b0;
            w_flush    = 1'b0;
            w_last     = 1'b0;
            w_release  = 1'b0;
        end
    end

    assign w_issue = w_req & mem_gnt_i;

    always_ff @(posedge clk) begin
        if (w_rst) begin
            r_issue_cnt <= '0;
            r_cap_cnt   <= '0;
            r_pend      <= 1'b0;
            r_pend_idx  <= '0;
            r_fpc       <= '0;
            r_pc        <= '0;
            r_inst      <= '0;
            r_valid     <= 1'b0;
        end else if (w_flush) begin
            r_issue_cnt <= '0;
            r_cap_cnt   <= '0;
            r_pend      <= 1'b0;
            r_valid     <= 1'b0;
        end else begin
            if (w_start) begin
                r_fpc       <= pc_i;
                r_issue_cnt <= '0;
                r_cap_cnt   <= '0;
                r_pend      <= 1'b0;
            end
            if (r_state == ST_FETCH) begin
                if (w_issue) begin
                    r_issue_cnt <= r_issue_cnt + 3'd1;
                    r_pend      <= 1'b1;
                    r_pend_idx  <= r_issue_cnt[1:0];
                end else begin
                    r_pend <= 1'b0;
                end
                if (r_pend) begin
                    r_cap_cnt <= r_cap_cnt + 3'd1;
                end
                if (w_last) begin
                    r_inst  <= w_word;
                    r_pc    <= r_fpc;
                    r_valid <= 1'b1;
                end
            end
            if (w_release) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign w_we  = (r_state == ST_FETCH) && r_pend && !w_flush;
    assign w_clr = w_start | w_flush;

    fetch_byte_asm u_asm (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_clr),
        .i_we   (w_we),
        .i_idx  (r_pend_idx),
        .i_byte (mem_din_i),
        .o_word (w_word)
    );

    assign mem_req_o  = w_req;
    assign mem_addr_o = w_req ? r_fpc + ADDR_W'(r_issue_cnt) : '0;
    assign stallreq_o = w_stallreq;
    assign if_pc_o    = r_pc;
    assign if_inst_o  = r_inst;
    assign if_valid_o = r_valid;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: vector table, corner sequences, and a random
// instruction-stream run checked against a sequential-fetch model.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_i;
    logic        ce_i;
    logic        set_pc_i;
    logic [5:0]  stall;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i;
    logic [7:0]  mem_din_i;
    logic        stallreq_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_inst_o;
    logic        if_valid_o;

    int          n_vec = 0;
    int          n_bad = 0;
    logic        last_iss;
    logic [31:0] last_addr;

    typedef struct packed {
        logic        ce;
        logic [31:0] pc;
        logic        gnt;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic        sreq;
        logic [31:0] inst;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    if_fetch dut (
        .clk        (clk),
        .rst        (rst),
        .pc_i       (pc_i),
        .ce_i       (ce_i),
        .set_pc_i   (set_pc_i),
        .stall      (stall),
        .mem_req_o  (mem_req_o),
        .mem_addr_o (mem_addr_o),
        .mem_gnt_i  (mem_gnt_i),
        .mem_din_i  (mem_din_i),
        .stallreq_o (stallreq_o),
        .if_pc_o    (if_pc_o),
        .if_inst_o  (if_inst_o),
        .if_valid_o (if_valid_o)
    );

    // memory image: fixed program bytes at 0x1000, hash elsewhere
    function automatic logic [7:0] mb(input logic [31:0] a);
        case (a)
            32'h1000: return 8'h13;
            32'h1001: return 8'h05;
            32'h1002: return 8'h10;
            32'h1003: return 8'h00;
            default:  return 8'(a ^ (a >> 8) ^ (a >> 19) ^ 32'hA5);
        endcase
    endfunction

    function automatic logic [31:0] minst(input logic [31:0] p);
        return {mb(p + 32'd3), mb(p + 32'd2), mb(p + 32'd1), mb(p)};
    endfunction

    function automatic vec_t row(
        input logic ce, input logic [31:0] pc, input logic gnt,
        input logic req, input logic [31:0] addr,
        input logic vld, input logic sreq, input logic [31:0] inst
    );
        vec_t r;
        r.ce   = ce;
        r.pc   = pc;
        r.gnt  = gnt;
        r.req  = req;
        r.addr = addr;
        r.vld  = vld;
        r.sreq = sreq;
        r.inst = inst;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    // one clock; memory answers a granted issue on the following cycle
    task automatic tick();
        #1;
        last_iss  = mem_req_o && mem_gnt_i;
        last_addr = mem_addr_o;
        @(posedge clk);
        @(negedge clk);
        mem_din_i = last_iss ? mb(last_addr) : 8'($urandom);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_req"},   32'(mem_req_o),  0);
        chk({tag, "_addr"},  mem_addr_o,      0);
        chk({tag, "_sreq"},  32'(stallreq_o), 0);
        chk({tag, "_valid"}, 32'(if_valid_o), 0);
        chk({tag, "_pc"},    if_pc_o,         0);
        chk({tag, "_inst"},  if_inst_o,       0);
    endtask

    initial begin
        logic [31:0] i0;
        logic [31:0] pw;
        logic [31:0] exp_pc;
        int          nib;
        int          since;

        i0 = 32'h0010_0513;
        pw = 32'hFFFF_FFFE;
        // basic fetch at 0x1000, gnt always high
        tbl.push_back(row(1, 32'h1000, 1, 0, 0,        0, 1, 0));
        tbl.push_back(row(1, 32'h1000, 1, 1, 32'h1000, 0, 1, 0));
        tbl.push_back(row(1, 32'h1000, 1, 1, 32'h1001, 0, 1, 0));
        tbl.push_back(row(1, 32'h1000, 1, 1, 32'h1002, 0, 1, 0));
        tbl.push_back(row(1, 32'h1000, 1, 1, 32'h1003, 0, 1, 0));
        tbl.push_back(row(1, 32'h1000, 1, 0, 0,        0, 1, 0));
        tbl.push_back(row(0, 32'h1000, 1, 0, 0,        1, 0, i0));
        tbl.push_back(row(0, 32'h1000, 1, 0, 0,        0, 0, 0));
        // grant gaps on T+2, T+3
        tbl.push_back(row(1, 32'h1000, 1, 0, 0,        0, 1, 0));
        tbl.push_back(row(1, 32'h1000, 1, 1, 32'h1000, 0, 1, 0));
        tbl.push_back(row(1, 32'h1000, 0, 1, 32'h1001, 0, 1, 0));
        tbl.push_back(row(1, 32'h1000, 0, 1, 32'h1001, 0, 1, 0));
        tbl.push_back(row(1, 32'h1000, 1, 1, 32'h1001, 0, 1, 0));
        tbl.push_back(row(1, 32'h1000, 1, 1, 32'h1002, 0, 1, 0));
        tbl.push_back(row(1, 32'h1000, 1, 1, 32'h1003, 0, 1, 0));
        tbl.push_back(row(1, 32'h1000, 1, 0, 0,        0, 1, 0));
        tbl.push_back(row(0, 32'h1000, 1, 0, 0,        1, 0, i0));
        tbl.push_back(row(0, 32'h1000, 1, 0, 0,        0, 0, 0));
        // address wrap
        tbl.push_back(row(1, pw, 1, 0, 0,            0, 1, 0));
        tbl.push_back(row(1, pw, 1, 1, 32'hFFFFFFFE, 0, 1, 0));
        tbl.push_back(row(1, pw, 1, 1, 32'hFFFFFFFF, 0, 1, 0));
        tbl.push_back(row(1, pw, 1, 1, 32'h0,        0, 1, 0));
        tbl.push_back(row(1, pw, 1, 1, 32'h1,        0, 1, 0));
        tbl.push_back(row(1, pw, 1, 0, 0,            0, 1, 0));
        tbl.push_back(row(0, pw, 1, 0, 0,            1, 0, minst(pw)));
        tbl.push_back(row(0, pw, 1, 0, 0,            0, 0, 0));

        rst       = 1'b0;
        ce_i      = 1'b0;
        set_pc_i  = 1'b0;
        pc_i      = '0;
        stall     = '0;
        mem_gnt_i = 1'b0;
        mem_din_i = '0;
        @(negedge clk);
        tick();
        tick();
        chk_zero("reset");
        rst = 1'b1;
        tick();

        foreach (tbl[i]) begin
            ce_i      = tbl[i].ce;
            pc_i      = tbl[i].pc;
            mem_gnt_i = tbl[i].gnt;
            #1;
            chk($sformatf("tbl%0d_req", i),   32'(mem_req_o),  32'(tbl[i].req));
            chk($sformatf("tbl%0d_addr", i),  mem_addr_o,      tbl[i].addr);
            chk($sformatf("tbl%0d_valid", i), 32'(if_valid_o), 32'(tbl[i].vld));
            chk($sformatf("tbl%0d_sreq", i),  32'(stallreq_o), 32'(tbl[i].sreq));
            if (tbl[i].vld) begin
                chk($sformatf("tbl%0d_inst", i), if_inst_o, tbl[i].inst);
                chk($sformatf("tbl%0d_pc", i),   if_pc_o,   tbl[i].pc);
            end
            tick();
        end

        // reset for three cycles in the middle of a fetch
        ce_i      = 1'b1;
        pc_i      = 32'h3000;
        mem_gnt_i = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_zero($sformatf("midrst%0d", k));
        end
        rst  = 1'b1;
        ce_i = 1'b0;
        #1;
        chk("postrst_req",  32'(mem_req_o),  0);
        chk("postrst_sreq", 32'(stallreq_o), 0);

        // back-pressure in DONE, then advance to pc+4
        stall = 6'b000010;
        ce_i  = 1'b1;
        pc_i  = 32'h1000;
        repeat (6) tick();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("bp%0d_valid", k), 32'(if_valid_o), 1);
            chk($sformatf("bp%0d_inst", k),  if_inst_o,       i0);
            chk($sformatf("bp%0d_sreq", k),  32'(stallreq_o), 0);
            chk($sformatf("bp%0d_req", k),   32'(mem_req_o),  0);
            tick();
        end
        stall = '0;
        tick();
        pc_i = 32'h1004;
        #1;
        chk("bp_rel_valid", 32'(if_valid_o), 0);
        chk("bp_rel_sreq",  32'(stallreq_o), 1);
        tick();
        chk("bp_next_addr", mem_addr_o, 32'h1004);
        repeat (5) tick();
        chk("bp_next_valid", 32'(if_valid_o), 1);
        chk("bp_next_inst",  if_inst_o,       minst(32'h1004));
        ce_i = 1'b0;
        tick();

        // redirect after byte 1 issued
        ce_i = 1'b1;
        pc_i = 32'h1000;
        repeat (3) tick();
        set_pc_i = 1'b1;
        pc_i     = 32'h2000;
        tick();
        set_pc_i = 1'b0;
        #1;
        chk("redir_req",   32'(mem_req_o),  0);
        chk("redir_valid", 32'(if_valid_o), 0);
        tick();
        chk("redir_addr", mem_addr_o, 32'h2000);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("redir_wait%0d", k), 32'(if_valid_o), 0);
        end
        tick();
        chk("redir_valid2", 32'(if_valid_o), 1);
        chk("redir_pc",     if_pc_o,         32'h2000);
        chk("redir_inst",   if_inst_o,       minst(32'h2000));
        ce_i = 1'b0;
        tick();

        // random run: in-order stream from exp_pc, restarted by redirects
        exp_pc = $urandom & 32'hFFFF_FFFC;
        pc_i   = exp_pc;
        ce_i   = 1'b1;
        nib    = 0;
        since  = 0;
        for (int c = 0; c < 1500; c++) begin
            logic        redir;
            logic        acc;
            logic [31:0] tgt;
            redir     = ($urandom_range(0, 39) == 0);
            tgt       = $urandom;
            mem_gnt_i = ($urandom_range(0, 3) != 0);
            stall     = {4'b0, ($urandom_range(0, 2) == 0), 1'b0};
            set_pc_i  = redir;
            if (redir) pc_i = tgt;
            #1;
            acc = 1'b0;
            if (!redir) begin
                if (mem_req_o && mem_gnt_i) begin
                    chk("rnd_addr", mem_addr_o, exp_pc + 32'(nib));
                    nib++;
                end
                if (if_valid_o && !stall[1]) begin
                    chk("rnd_nbytes", 32'(nib), 4);
                    chk("rnd_pc",     if_pc_o,   exp_pc);
                    chk("rnd_inst",   if_inst_o, minst(exp_pc));
                    acc = 1'b1;
                end
            end
            if (if_valid_o) begin
                chk("rnd_done_sreq", 32'(stallreq_o), 0);
            end
            since = (acc || redir) ? 0 : since + 1;
            if (since > 80) begin
                n_vec++;
                n_bad++;
                $display("FAIL rnd_timeout: no instruction for %0d cycles, want <= 80", since);
                break;
            end
            tick();
            set_pc_i = 1'b0;
            if (redir) begin
                exp_pc = tgt;
                nib    = 0;
            end
            if (acc) begin
                exp_pc = exp_pc + 32'd4;
                nib    = 0;
                pc_i   = exp_pc;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
